xs3_to_bcd_packer: RTL and testbench

Streaming excess-3 to BCD decoder and word packer: the receive-side counterpart of the combinational 4-bit code converter. It accepts one excess-3 digit per valid/ready handshake, subtracts the offset of 3 to get BCD, and shifts the digits into an NDIG-digit packed BCD word, most significant digit first. It presents each completed or early-terminated word on a valid/ready output. It sits between the digit-serial code-converter path and any consumer that needs packed BCD (display drivers, BCD arithmetic).

---
 rtl/xs3_pkg.sv | 10 +
 rtl/xs3_digit_dec.sv | 24 ++
 rtl/xs3_to_bcd_packer.sv | 77 +++++++
 tb/tb_xs3_to_bcd_packer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/xs3_pkg.sv
// Shared constants and state type for the excess-3 to BCD packer.
// The XS3_ERR_EN macro selects invalid-code detection in xs3_digit_dec.
package xs3_pkg;
  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] XS3_MIN     = 4'd3;
  localparam logic [3:0] XS3_MAX     = 4'd12;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic {FILL, HOLD} state_t;
endpackage

// File: rtl/xs3_digit_dec.sv
// Single-digit excess-3 to BCD decoder, purely combinational.
// With XS3_ERR_EN defined, codes outside 3..12 flag invalid and decode to 0xF.
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] in_digit,
  output logic [3:0] bcd,
  output logic       invalid
);

`ifdef XS3_ERR_EN
  always_comb begin
    invalid = (in_digit < XS3_MIN) || (in_digit > XS3_MAX);
    bcd     = invalid ? BCD_INVALID : (in_digit - XS3_OFFSET);
  end
`else
  // No checking: the nibble simply wraps modulo 16.
  always_comb begin
    invalid = 1'b0;
    bcd     = in_digit - XS3_OFFSET;
  end
`endif

endmodule

// File: rtl/xs3_to_bcd_packer.sv
// Streams excess-3 digits in, packs them MSD-first into NDIG-digit BCD words.
// state | meaning:  FILL | accumulating digits;  HOLD | word presented on output.
// Error reporting depends on XS3_ERR_EN (see xs3_digit_dec).
module xs3_to_bcd_packer
  import xs3_pkg::*;
#(
  parameter  int NDIG = 4,
  localparam int CW   = $clog2(NDIG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_digit,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_data,
  output logic [CW-1:0]     out_ndig,
  output logic              out_err
);

  state_t            state, state_nxt;
  logic [3:0]        bcd;
  logic              invalid;
  logic              accept, complete;
  logic [4*NDIG-1:0] acc, acc_nxt;
  logic [CW-1:0]     cnt;
  logic              err_acc;

  xs3_digit_dec u_dec (
    .in_digit (in_digit),
    .bcd      (bcd),
    .invalid  (invalid)
  );

  assign out_valid = (state == HOLD);
  // Depends only on registered state and out_ready, never on in_valid.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign complete  = accept && (in_last || (cnt == CW'(NDIG - 1)));
  assign acc_nxt   = {acc[4*NDIG-5:0], bcd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (complete)                    state_nxt = HOLD;
    else if (out_valid && out_ready) state_nxt = FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      err_acc  <= 1'b0;
      out_data <= '0;
      out_ndig <= '0;
      out_err  <= 1'b0;
    end else if (complete) begin
      out_data <= acc_nxt;
      out_ndig <= cnt + CW'(1);
      out_err  <= err_acc | invalid;
      acc      <= '0;
      cnt      <= '0;
      err_acc  <= 1'b0;
    end else if (accept) begin
      acc      <= acc_nxt;
      cnt      <= cnt + CW'(1);
      err_acc  <= err_acc | invalid;
    end
  end

endmodule

// File: tb/tb_xs3_to_bcd_packer.sv
// Directed self-checking bench for xs3_to_bcd_packer with NDIG=4.
// Expected values for the bad-code word follow XS3_ERR_EN.
module tb_xs3_to_bcd_packer;
  localparam int NDIG = 4;
  localparam int CW   = $clog2(NDIG + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_digit;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] out_data;
  logic [CW-1:0]     out_ndig;
  logic              out_err;

  int tests = 0;
  int fails = 0;

  xs3_to_bcd_packer #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ndig  (out_ndig),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one digit and hold it for exactly one clock edge.
  task automatic put(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    #1;
    chk("in_ready_put", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_digit  = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, out_data},  32'h0);
    chk("rst_out_ndig",  {29'd0, out_ndig},  32'd0);
    chk("rst_out_err",   {31'd0, out_err},   32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    rst = 1'b0;
    tick();

    // Full word 1234
    put(4'h4, 1'b0);
    put(4'h5, 1'b0);
    put(4'h6, 1'b0);
    chk("w1_not_yet", {31'd0, out_valid}, 32'd0);
    put(4'h7, 1'b0);
    chk("w1_valid", {31'd0, out_valid}, 32'd1);
    chk("w1_data",  {16'd0, out_data},  32'h1234);
    chk("w1_ndig",  {29'd0, out_ndig},  32'd4);
    chk("w1_err",   {31'd0, out_err},   32'd0);
    tick();
    chk("w1_taken", {31'd0, out_valid}, 32'd0);

    // Early in_last: right-justified 0x0090
    put(4'hC, 1'b0);
    put(4'h3, 1'b1);
    chk("w2_valid", {31'd0, out_valid}, 32'd1);
    chk("w2_data",  {16'd0, out_data},  32'h0090);
    chk("w2_ndig",  {29'd0, out_ndig},  32'd2);
    tick();

    // Backpressure: word 5678 held for 5 cycles while a digit is offered
    out_ready = 1'b0;
    put(4'h8, 1'b0);
    put(4'h9, 1'b0);
    put(4'hA, 1'b0);
    put(4'hB, 1'b0);
    in_valid = 1'b1;
    in_digit = 4'h4;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", {31'd0, in_ready},  32'd0);
      chk("stall_valid",    {31'd0, out_valid}, 32'd1);
      chk("stall_data",     {16'd0, out_data},  32'h5678);
      tick();
    end
    in_digit  = 4'hC;
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("release_taken", {31'd0, out_valid}, 32'd0);
    put(4'h3, 1'b0);
    put(4'h4, 1'b1);
    chk("w4_data", {16'd0, out_data}, 32'h0901);
    chk("w4_ndig", {29'd0, out_ndig}, 32'd3);

    // Back-to-back streaming 5678 / 9012, then a 1-digit word loaded in HOLD
    put(4'h8, 1'b0);
    put(4'h9, 1'b0);
    put(4'hA, 1'b0);
    put(4'hB, 1'b0);
    chk("s1_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_data",  {16'd0, out_data},  32'h5678);
    put(4'hC, 1'b0);
    put(4'h3, 1'b0);
    put(4'h4, 1'b0);
    put(4'h5, 1'b0);
    chk("s2_valid", {31'd0, out_valid}, 32'd1);
    chk("s2_data",  {16'd0, out_data},  32'h9012);
    chk("s2_ndig",  {29'd0, out_ndig},  32'd4);
    put(4'h7, 1'b1);
    chk("s3_valid", {31'd0, out_valid}, 32'd1);
    chk("s3_data",  {16'd0, out_data},  32'h0004);
    chk("s3_ndig",  {29'd0, out_ndig},  32'd1);
    tick();

    // Invalid code in second position
    put(4'h4, 1'b0);
    put(4'h1, 1'b0);
    put(4'h5, 1'b0);
    put(4'h6, 1'b0);
`ifdef XS3_ERR_EN
    chk("bad_data", {16'd0, out_data}, 32'h1F23);
    chk("bad_err",  {31'd0, out_err},  32'd1);
`else
    chk("bad_data", {16'd0, out_data}, 32'h1E23);
    chk("bad_err",  {31'd0, out_err},  32'd0);
`endif
    tick();
    // Clean word after it; in_last on the 4th digit is redundant
    put(4'h4, 1'b0);
    put(4'h5, 1'b0);
    put(4'h6, 1'b0);
    put(4'h7, 1'b1);
    chk("clean_data", {16'd0, out_data}, 32'h1234);
    chk("clean_ndig", {29'd0, out_ndig}, 32'd4);
    chk("clean_err",  {31'd0, out_err},  32'd0);
    tick();

    // Asynchronous reset with a partial word pending
    put(4'h4, 1'b0);
    put(4'h5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",    {31'd0, out_valid}, 32'd0);
    chk("arst_data",     {16'd0, out_data},  32'h0);
    chk("arst_ndig",     {29'd0, out_ndig},  32'd0);
    chk("arst_in_ready", {31'd0, in_ready},  32'd1);
    tick();
    rst = 1'b0;
    tick();
    put(4'h9, 1'b0);
    put(4'hA, 1'b0);
    put(4'hB, 1'b0);
    chk("fresh_not_yet", {31'd0, out_valid}, 32'd0);
    put(4'hC, 1'b0);
    chk("fresh_valid", {31'd0, out_valid}, 32'd1);
    chk("fresh_data",  {16'd0, out_data},  32'h6789);
    chk("fresh_ndig",  {29'd0, out_ndig},  32'd4);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
